// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, N combinational read ports with
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NREAD*AW-1:0]    RAddr,
  output logic [NREAD*WIDTH-1:0] RData,
  output logic [NREAD-1:0]       RBusy,
  input  logic [AW-1:0]          RW0,
  input  logic [WIDTH-1:0]       BusW0,
  input  logic                   RegWr0,
  input  logic [AW-1:0]          RW1,
  input  logic [WIDTH-1:0]       BusW1,
  input  logic                   RegWr1,
  input  logic                   Rsv,
  input  logic [AW-1:0]          RsvAddr,
  output logic [DEPTH-1:0]       Busy,
  input  logic [AW-1:0]          DbgAddr,
  output logic [WIDTH-1:0]       DbgData
);

  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_dbg_zero;

  genvar gi;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX      = AW'(gi);
      localparam bit            WRITABLE = (ZERO_REG == 0) || (gi != 0);

      logic [WIDTH-1:0] r_data;
      logic             r_busy;
      logic             w_wr0;
      logic             w_wr1;
      logic             w_rsv;

      assign w_wr0 = WRITABLE && RegWr0 && (RW0 == IDX);
      assign w_wr1 = WRITABLE && RegWr1 && (RW1 == IDX);
      assign w_rsv = WRITABLE && Rsv && (RsvAddr == IDX);

      // A same-cycle reservation belongs to a newer producer, so it beats the clear.
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_wr1)
            r_data <= BusW1;
          else if (w_wr0)
            r_data <= BusW0;
          if (w_rsv)
            r_busy <= 1'b1;
          else if (w_wr0 || w_wr1)
            r_busy <= 1'b0;
        end
      end

      assign w_mem[gi]  = r_data;
      assign w_busy[gi] = r_busy;
    end
  endgenerate

  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]    w_addr;
      logic             w_hit0;
      logic             w_hit1;
      logic             w_zero;
      logic [WIDTH-1:0] w_data;

      assign w_addr = RAddr[gi*AW +: AW];
      assign w_hit0 = RegWr0 && (RW0 == w_addr);
      assign w_hit1 = RegWr1 && (RW1 == w_addr);
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

      always_comb begin
        w_data = w_mem[w_addr];
        if (w_zero)
          w_data = '0;
        else if (w_hit1)
          w_data = BusW1;
        else if (w_hit0)
          w_data = BusW0;
      end

      // A register written this cycle is ready through the bypass.
      assign RData[gi*WIDTH +: WIDTH] = Rst ? w_data : '0;
      assign RBusy[gi] = Rst && w_busy[w_addr] && !(w_hit0 || w_hit1);
    end
  endgenerate

  assign w_dbg_zero = (ZERO_REG != 0) && (DbgAddr == '0);
  assign DbgData    = (Rst && !w_dbg_zero) ? w_mem[DbgAddr] : '0;
  assign Busy       = Rst ? w_busy : '0;

endmodule
